// File: rtl/sara_err_recover.sv
// sara_err_recover -- carry-speculative adder with error detection and
// optional one-cycle exact-sum recovery.
//
// The operands are split into SIZE/GROUP_SIZE groups. Each group's carry-out
// is either exact (select[k]=1) or predicted from the group's top operand bits
// (select[k]=0). The speculative sum ripples these predicted carries between
// groups. A mispredicted group is reported in err_groups and counted in
// err_count.
//
// Build option: define SARA_ERR_RECOVERY_EN to add the FIX state. A
// mispredicted transaction is then redelivered with the exact sum, one cycle
// later. Without the macro the speculative result is always delivered, and
// the error reporting is still active.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, cin, select)
//   out_valid/out_ready result handshake (sum, cout, err_flag, err_groups)
//   err_count           saturating count of mispredicted transactions
module sara_err_recover #(
  parameter int SIZE       = 32,
  parameter int GROUP_SIZE = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE-1:0]            a,
  input  logic [SIZE-1:0]            b,
  input  logic                       cin,
  input  logic [SIZE/GROUP_SIZE-1:0] select,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIZE-1:0]            sum,
  output logic                       cout,
  output logic                       err_flag,
  output logic [SIZE/GROUP_SIZE-1:0] err_groups,
  output logic [15:0]                err_count
);

  localparam int N  = SIZE / GROUP_SIZE;
  localparam int GW = GROUP_SIZE + 1;

`ifdef SARA_ERR_RECOVERY_EN
  typedef enum logic [1:0] {IDLE, SPEC, FIX, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, SPEC, HOLD} state_t;
`endif

  state_t state, state_next;

  logic [SIZE-1:0] a_q, b_q;
  logic            cin_q;
  logic [N-1:0]    select_q;
  logic            accept;

  logic [N-1:0]    exact_c, spec_c, err_vec;
  logic [SIZE-1:0] spec_sum;
  logic [15:0]     err_cnt_q;

  assign accept = in_valid && (state == IDLE);

  // Operand capture; later input changes do not affect the transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      select_q <= '0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      cin_q    <= cin;
      select_q <= select;
    end
  end

  // Two carry chains: the exact chain ripples true group carries, and the
  // speculative chain ripples the selected or predicted carry of each group.
  always_comb begin
    logic c_ex, c_sp;
    exact_c  = '0;
    spec_c   = '0;
    spec_sum = '0;
    c_ex     = cin_q;
    c_sp     = cin_q;
    for (int unsigned k = 0; k < N; k++) begin
      c_ex = 1'((GW'(a_q[k*GROUP_SIZE +: GROUP_SIZE]) +
                 GW'(b_q[k*GROUP_SIZE +: GROUP_SIZE]) + GW'(c_ex)) >> GROUP_SIZE);
      exact_c[k] = c_ex;
      spec_sum[k*GROUP_SIZE +: GROUP_SIZE] = a_q[k*GROUP_SIZE +: GROUP_SIZE] +
                                             b_q[k*GROUP_SIZE +: GROUP_SIZE] +
                                             GROUP_SIZE'(c_sp);
      spec_c[k] = select_q[k] ? c_ex
                              : (a_q[k*GROUP_SIZE+GROUP_SIZE-1] & b_q[k*GROUP_SIZE+GROUP_SIZE-1]);
      c_sp = spec_c[k];
    end
  end

  assign err_vec = spec_c ^ exact_c;

`ifdef SARA_ERR_RECOVERY_EN
  localparam int SW = SIZE + 1;
  logic [SIZE:0] exact_full;
  assign exact_full = {1'b0, a_q} + {1'b0, b_q} + SW'(cin_q);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = SPEC;
`ifdef SARA_ERR_RECOVERY_EN
      SPEC: state_next = (|err_vec) ? FIX : HOLD;
      FIX:  state_next = HOLD;
`else
      SPEC: state_next = HOLD;
`endif
      HOLD: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
  end

  // Result registers are written only in SPEC/FIX, so they stay frozen
  // throughout HOLD. In a recovering build a mispredicted SPEC cycle loads
  // the speculative value first, and FIX then overwrites sum and cout before
  // out_valid rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum        <= '0;
      cout       <= 1'b0;
      err_flag   <= 1'b0;
      err_groups <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (state == SPEC) begin
        sum        <= spec_sum;
        cout       <= spec_c[N-1];
        err_flag   <= |err_vec;
        err_groups <= err_vec;
        if ((|err_vec) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 16'd1;
      end
`ifdef SARA_ERR_RECOVERY_EN
      if (state == FIX) begin
        sum  <= exact_full[SIZE-1:0];
        cout <= exact_full[SIZE];
      end
`endif
    end
  end

  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_sara_err_recover.sv
// Self-checking bench for sara_err_recover (default SIZE=32, GROUP_SIZE=4).
module tb_sara_err_recover;

`ifdef SARA_ERR_RECOVERY_EN
  localparam bit REC = 1'b1;
`else
  localparam bit REC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        cin;
  logic [7:0]  select;
  logic        out_valid, out_ready;
  logic [31:0] sum;
  logic        cout, err_flag;
  logic [7:0]  err_groups;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic sat_req = 1'b0;

  sara_err_recover #(.SIZE(32), .GROUP_SIZE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .select(select),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err_flag(err_flag), .err_groups(err_groups),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: exact carries from prefix sums, speculative sum
  // built group by group from the predicted carries.
  function automatic void model_calc(
    input  logic [31:0] ma, mb, input logic mc, input logic [7:0] ms,
    output logic [31:0] xsum, output logic xcout, output logic [7:0] xerr,
    output logic [31:0] ssum, output logic scout);
    logic [63:0] full, part, mask, g;
    logic [7:0]  e, s;
    logic        c;
    full = 64'(ma) + 64'(mb) + 64'(mc);
    for (int k = 0; k < 8; k++) begin
      mask = (64'd1 << (4*k+4)) - 64'd1;
      part = (64'(ma) & mask) + (64'(mb) & mask) + 64'(mc);
      e[k] = part[4*k+4];
      s[k] = ms[k] ? e[k] : (ma[4*k+3] & mb[4*k+3]);
    end
    ssum = '0;
    c = mc;
    for (int k = 0; k < 8; k++) begin
      g = ((64'(ma) >> (4*k)) & 64'hF) + ((64'(mb) >> (4*k)) & 64'hF) + 64'(c);
      ssum = ssum | (32'(g & 64'hF) << (4*k));
      c = s[k];
    end
    xsum  = full[31:0];
    xcout = full[32];
    xerr  = s ^ e;
    scout = s[7];
  endfunction

  // Transaction-level model: tracks age of the current transaction
  logic        m_busy = 1'b0, m_valid = 1'b0, m_err = 1'b0;
  int          m_age = 0, m_lat = 1;
  logic [15:0] m_count = '0;
  logic [31:0] m_sum = '0;
  logic        m_cout = 1'b0;
  logic [7:0]  m_groups = '0;

  always @(posedge clk or posedge rst) begin
    logic [31:0] xs, ss;
    logic        xc, sc;
    logic [7:0]  xe;
    if (rst) begin
      m_busy = 1'b0; m_valid = 1'b0; m_age = 0; m_count = '0;
      m_sum = '0; m_cout = 1'b0; m_err = 1'b0; m_groups = '0;
    end else begin
      if (sat_req) m_count = 16'hFFFF;
      if (m_valid) begin
        if (out_ready) begin m_valid = 1'b0; m_busy = 1'b0; end
      end else if (m_busy) begin
        m_age++;
        if (m_age == 1 && m_err && m_count != 16'hFFFF) m_count++;
        if (m_age == m_lat) m_valid = 1'b1;
      end else if (in_valid) begin
        model_calc(a, b, cin, select, xs, xc, xe, ss, sc);
        m_err    = (xe != 8'h00);
        m_groups = xe;
        if (REC && m_err) begin m_sum = xs; m_cout = xc; m_lat = 2; end
        else              begin m_sum = ss; m_cout = sc; m_lat = 1; end
        m_busy = 1'b1;
        m_age  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", 64'(in_ready), 64'(!m_busy));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("err_count", 64'(err_count), 64'(m_count));
      if (m_valid) begin
        check("sum", 64'(sum), 64'(m_sum));
        check("cout", 64'(cout), 64'(m_cout));
        check("err_flag", 64'(err_flag), 64'(m_err));
        check("err_groups", 64'(err_groups), 64'(m_groups));
      end
    end
  end

  task automatic send(input logic [31:0] ta, tbv, input logic tc, input logic [7:0] ts,
                      input logic early, output int lat);
    logic [31:0] xs, ss;
    logic        xc, sc;
    logic [7:0]  xe;
    int          exp_lat;
    model_calc(ta, tbv, tc, ts, xs, xc, xe, ss, sc);
    exp_lat = (REC && (xe != 8'h00)) ? 2 : 1;
    @(negedge clk);
    a = ta; b = tbv; cin = tc; select = ts; in_valid = 1'b1; out_ready = early;
    @(negedge clk);
    in_valid = 1'b0; a = ~ta; b = tbv ^ 32'h5A5A_5A5A; cin = ~tc; select = ~ts;
    lat = 0;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
  endtask

  task automatic finish_txn();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_release", 64'(in_ready), 64'd1);
  endtask

  logic [31:0] va [6] = '{32'h1234_5678, 32'hFFFF_0000, 32'h7777_7777,
                          32'h0F0F_0F0F, 32'h8000_0000, 32'hDEAD_BEEF};
  logic [31:0] vb [6] = '{32'h9ABC_DEF0, 32'h0000_FFFF, 32'h1111_1111,
                          32'h0101_0101, 32'h8000_0000, 32'h2152_4111};
  logic        vc [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0]  vs [6] = '{8'h00, 8'hAA, 8'h00, 8'h55, 8'h00, 8'h0F};

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; select = '0;
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_err_flag", 64'(err_flag), 64'd0);
    check("rst_err_groups", 64'(err_groups), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Group 0 mispredicted: exact 0x10, speculative 0x00
    send(32'h0000_000F, 32'h0000_0001, 1'b0, 8'h00, 1'b0, lat);
`ifdef SARA_ERR_RECOVERY_EN
    check("pin1_lat", 64'(lat), 64'd2);
    check("pin1_sum", 64'(sum), 64'h10);
`else
    check("pin1_lat", 64'(lat), 64'd1);
    check("pin1_sum", 64'(sum), 64'h0);
`endif
    check("pin1_cout", 64'(cout), 64'd0);
    check("pin1_err_flag", 64'(err_flag), 64'd1);
    check("pin1_err_groups", 64'(err_groups), 64'h01);
    check("pin1_err_count", 64'(err_count), 64'd1);
    hold(5);
    finish_txn();

    // All groups exact: full carry ripple to cout
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 8'hFF, 1'b0, lat);
    check("pin2_lat", 64'(lat), 64'd1);
    check("pin2_sum", 64'(sum), 64'h0);
    check("pin2_cout", 64'(cout), 64'd1);
    check("pin2_err_flag", 64'(err_flag), 64'd0);
    check("pin2_err_count", 64'(err_count), 64'd1);
    finish_txn();

    // Group 1 mispredicted: exact 0x100, speculative 0x000
    send(32'h0000_0070, 32'h0000_0090, 1'b0, 8'h00, 1'b0, lat);
`ifdef SARA_ERR_RECOVERY_EN
    check("pin3_sum", 64'(sum), 64'h100);
`else
    check("pin3_sum", 64'(sum), 64'h0);
`endif
    check("pin3_err_groups", 64'(err_groups), 64'h02);
    check("pin3_err_count", 64'(err_count), 64'd2);
    finish_txn();

    // Every group predicts correctly from its top bits
    send(32'h8888_8888, 32'h8888_8888, 1'b0, 8'h00, 1'b0, lat);
    check("pin4_sum", 64'(sum), 64'h1111_1110);
    check("pin4_cout", 64'(cout), 64'd1);
    check("pin4_err_flag", 64'(err_flag), 64'd0);
    finish_txn();

    // Directed vectors; odd entries run back-to-back with out_ready held high
    for (int i = 0; i < 6; i++) begin
      send(va[i], vb[i], vc[i], vs[i], 1'(i % 2), lat);
      if (i % 2 == 0) begin
        hold(1);
        finish_txn();
      end
    end
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while the mispredicted transaction is in flight
    @(negedge clk);
    a = 32'h0000_000F; b = 32'h0000_0001; cin = 1'b0; select = 8'h00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_err_count", 64'(err_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Saturation: preload the counter, then mispredict once more
    #2;
    force dut.err_cnt_q = 16'hFFFF;
    sat_req = 1'b1;
    @(posedge clk);
    #1;
    release dut.err_cnt_q;
    sat_req = 1'b0;
    send(32'h0000_000F, 32'h0000_0001, 1'b0, 8'h00, 1'b0, lat);
    check("sat_err_count", 64'(err_count), 64'hFFFF);
    finish_txn();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, test not completed");
    $fatal(1, "timeout");
  end

endmodule
